// File: rtl/adc_config_bank_if.sv
// AXI4-Lite slave bus for the ADC configuration bank.
// The master modport is the PS interconnect side; the slave modport is the register bank.
interface adc_config_bank_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/adc_config_bank.sv
// AXI4-Lite control/status bank for the ADC front end: R/W config words, RO status
// words and a command FIFO drained over AXI-Stream.
//
// write FSM state | meaning
// W_IDLE          | collecting AW and W, each accepted independently
// W_RESP          | write committed, holding bvalid/bresp until bready
//
// read FSM state  | meaning
// R_IDLE          | arready high, waiting for a read address
// R_DATA          | holding rvalid/rdata/rresp until rready
module adc_config_bank #(
    parameter int          NUM_CFG    = 4,
    parameter int          NUM_STATUS = 2,
    parameter int          FIFO_DEPTH = 16,
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] CFG_RESET  = 32'h0
) (
    input  logic                    aclk,
    input  logic                    areset,
    adc_config_bank_if.slave        s_axi_lite,
    output logic [32*NUM_CFG-1:0]   cfg,
    input  logic [32*NUM_STATUS-1:0] status,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WA_W-1:0] WA_CFG_END  = WA_W'(NUM_CFG);
    localparam logic [WA_W-1:0] WA_STAT     = WA_W'(64);
    localparam logic [WA_W-1:0] WA_STAT_END = WA_W'(64 + NUM_STATUS);
    localparam logic [WA_W-1:0] WA_PUSH     = WA_W'(128);
    localparam logic [WA_W-1:0] WA_LEVEL    = WA_W'(129);
    localparam logic [WA_W-1:0] WA_CTRL     = WA_W'(130);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_CFG, REG_STATUS, REG_PUSH, REG_LEVEL, REG_CTRL, REG_NONE
    } region_t;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic region_t decode(input logic [WA_W-1:0] wa);
        region_t r;
        if (wa < WA_CFG_END)                          r = REG_CFG;
        else if (wa >= WA_STAT && wa < WA_STAT_END)   r = REG_STATUS;
        else if (wa == WA_PUSH)                       r = REG_PUSH;
        else if (wa == WA_LEVEL)                      r = REG_LEVEL;
        else if (wa == WA_CTRL)                       r = REG_CTRL;
        else                                          r = REG_NONE;
        return r;
    endfunction

    wstate_t w_state;
    rstate_t r_state;

    logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    logic [32*NUM_CFG-1:0] cfg_q;
    logic [31:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  overflow_q;
    logic                  full;

    logic              aw_fire, w_fire, aw_have, w_have, commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [WA_W-1:0]   wr_wa;
    region_t           wr_region;
    logic              do_cfg, do_push, push_drop, do_ctrl, flush, pop;
    logic [1:0]        wr_resp;

    logic [WA_W-1:0]   rd_wa;
    region_t           rd_region;
    logic [31:0]       rd_data_next;
    logic [1:0]        rd_resp_next;

    assign full          = (count == CNT_W'(FIFO_DEPTH));
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = mem[rd_ptr];
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign cfg           = cfg_q;

    assign s_axi_lite.awready = awready_q;
    assign s_axi_lite.wready  = wready_q;
    assign s_axi_lite.bvalid  = bvalid_q;
    assign s_axi_lite.bresp   = bresp_q;
    assign s_axi_lite.arready = arready_q;
    assign s_axi_lite.rvalid  = rvalid_q;
    assign s_axi_lite.rdata   = rdata_q;
    assign s_axi_lite.rresp   = rresp_q;

    // A write commits on the edge where the second of AW/W arrives, so the
    // bus value is used when that channel has not been latched yet.
    assign aw_fire   = s_axi_lite.awvalid && awready_q;
    assign w_fire    = s_axi_lite.wvalid && wready_q;
    assign aw_have   = aw_held || aw_fire;
    assign w_have    = w_held || w_fire;
    assign commit    = (w_state == W_IDLE) && aw_have && w_have;
    assign wr_addr   = aw_held ? aw_addr_q : s_axi_lite.awaddr;
    assign wr_data   = w_held ? w_data_q : s_axi_lite.wdata;
    assign wr_strb   = w_held ? w_strb_q : s_axi_lite.wstrb;
    assign wr_wa     = wr_addr[ADDR_W-1:2];
    assign wr_region = decode(wr_wa);

    assign do_cfg    = commit && (wr_region == REG_CFG);
    assign do_push   = commit && (wr_region == REG_PUSH) && !full;
    assign push_drop = commit && (wr_region == REG_PUSH) && full;
    assign do_ctrl   = commit && (wr_region == REG_CTRL);
    assign flush     = do_ctrl && wr_data[1];

    always_comb begin
        wr_resp = RESP_SLVERR;
        if (wr_region == REG_CFG || wr_region == REG_CTRL ||
            (wr_region == REG_PUSH && !full))
            wr_resp = RESP_OKAY;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        w_state   <= W_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_resp;
                    end else begin
                        if (aw_fire) begin
                            aw_held   <= 1'b1;
                            aw_addr_q <= s_axi_lite.awaddr;
                            awready_q <= 1'b0;
                        end else if (!aw_held) begin
                            awready_q <= 1'b1;
                        end
                        if (w_fire) begin
                            w_held    <= 1'b1;
                            w_data_q  <= s_axi_lite.wdata;
                            w_strb_q  <= s_axi_lite.wstrb;
                            wready_q  <= 1'b0;
                        end else if (!w_held) begin
                            wready_q  <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_lite.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cfg_q      <= {NUM_CFG{CFG_RESET}};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_cfg) begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (wr_wa == WA_W'(i)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wr_strb[b])
                                cfg_q[32*i+8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
            if (push_drop)
                overflow_q <= 1'b1;
            else if (do_ctrl && wr_data[0])
                overflow_q <= 1'b0;
            // Flush discards a same-edge pop; a push cannot coincide with it.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({do_push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign rd_wa     = s_axi_lite.araddr[ADDR_W-1:2];
    assign rd_region = decode(rd_wa);

    always_comb begin
        rd_data_next = '0;
        rd_resp_next = RESP_OKAY;
        case (rd_region)
            REG_CFG: begin
                for (int i = 0; i < NUM_CFG; i++)
                    if (rd_wa == WA_W'(i))
                        rd_data_next = cfg_q[32*i +: 32];
            end
            REG_STATUS: begin
                for (int j = 0; j < NUM_STATUS; j++)
                    if (rd_wa == WA_STAT + WA_W'(j))
                        rd_data_next = status[32*j +: 32];
            end
            REG_LEVEL: rd_data_next = {14'b0, overflow_q, full, 16'(count)};
            REG_NONE:  rd_resp_next = RESP_SLVERR;
            default:   rd_data_next = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_lite.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_data_next;
                        rresp_q   <= rd_resp_next;
                        r_state   <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_lite.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi_lite.awprot, s_axi_lite.arprot,
                         wr_addr[1:0], s_axi_lite.araddr[1:0]};
endmodule

// File: tb/tb_adc_config_bank.sv
// Directed bench for adc_config_bank: stimulus pushes expected B/R/AXIS responses
// into queues, independent monitors pop and compare as the DUT presents them.
module tb_adc_config_bank;
    localparam int ADDR_W = 12;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         aclk = 1'b0;
    logic         areset;
    logic [127:0] cfg;
    logic [63:0]  status;
    logic [31:0]  tdata;
    logic         tvalid;
    logic         tready;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  b_q  [$];
    logic [33:0] r_q  [$];
    logic [31:0] ax_q [$];

    always #5 aclk = ~aclk;

    adc_config_bank_if #(.ADDR_W(ADDR_W)) bus ();

    adc_config_bank #(
        .NUM_CFG(4), .NUM_STATUS(2), .FIFO_DEPTH(16), .ADDR_W(ADDR_W), .CFG_RESET(32'h0)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axi_lite(bus),
        .cfg(cfg),
        .status(status),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=busy expected=done", name);
    endtask

    // monitors: handshake completes on the following rising edge
    always @(negedge aclk) begin
        if (!areset) begin
            if (bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected actual=%0h expected=none", bus.bresp);
                end else begin
                    chk("bresp", bus.bresp, b_q.pop_front());
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (r_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL r_unexpected actual=%0h expected=none", bus.rdata);
                end else begin
                    chk("rresp_rdata", {bus.rresp, bus.rdata}, r_q.pop_front());
                end
            end
            if (tvalid && tready) begin
                if (ax_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL axis_unexpected actual=%0h expected=none", tdata);
                end else begin
                    chk("axis_tdata", tdata, ax_q.pop_front());
                end
            end
        end
    end

    task automatic do_aw(input logic [ADDR_W-1:0] a);
        int n = 0;
        bus.awaddr = a; bus.awprot = 3'b0; bus.awvalid = 1'b1;
        @(negedge aclk);
        while (!bus.awready && n < 50) begin n++; @(negedge aclk); end
        if (!bus.awready) timeout("aw_handshake");
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        @(negedge aclk);
        while (!bus.wready && n < 50) begin n++; @(negedge aclk); end
        if (!bus.wready) timeout("w_handshake");
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [ADDR_W-1:0] a);
        int n = 0;
        bus.araddr = a; bus.arprot = 3'b0; bus.arvalid = 1'b1;
        @(negedge aclk);
        while (!bus.arready && n < 50) begin n++; @(negedge aclk); end
        if (!bus.arready) timeout("ar_handshake");
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_b_done();
        int n = 0;
        while (b_q.size() != 0 && n < 100) begin @(negedge aclk); n++; end
        if (b_q.size() != 0) begin timeout("b_response"); b_q.delete(); end
        @(posedge aclk); #1;
    endtask

    task automatic wait_r_done();
        int n = 0;
        while (r_q.size() != 0 && n < 100) begin @(negedge aclk); n++; end
        if (r_q.size() != 0) begin timeout("r_response"); r_q.delete(); end
        @(posedge aclk); #1;
    endtask

    task automatic wait_ax_done();
        int n = 0;
        while (ax_q.size() != 0 && n < 200) begin @(negedge aclk); n++; end
        if (ax_q.size() != 0) begin timeout("axis_drain"); ax_q.delete(); end
        @(posedge aclk); #1;
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] resp);
        b_q.push_back(resp);
        fork
            do_aw(a);
            do_w(d, s);
        join
        wait_b_done();
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [1:0] resp);
        r_q.push_back({resp, d});
        do_ar(a);
        wait_r_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset = 1'b1;
        tready = 1'b0;
        status = {32'hDEAD_BEEF, 32'h1357_9BDF};
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_cfg", cfg, 128'h0);
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("rel_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

        for (int i = 0; i < 4; i++) axi_read(ADDR_W'(4*i), 32'h0, OKAY);
        axi_write(12'h004, 32'hA5A5_5A5A, 4'b0011, OKAY);
        chk("cfg1_strb", cfg[63:32], 32'h0000_5A5A);
        axi_read(12'h004, 32'h0000_5A5A, OKAY);

        // AW three cycles ahead of W
        b_q.push_back(OKAY);
        fork
            begin
                do_aw(12'h008);
                chk("aw_first_awready", bus.awready, 0);
                chk("aw_first_wready", bus.wready, 1);
                chk("aw_first_bvalid", bus.bvalid, 0);
            end
            begin
                repeat (3) @(posedge aclk);
                #1;
                do_w(32'h1111_2222, 4'hF);
            end
        join
        wait_b_done();
        chk("cfg2_aw_first", cfg[95:64], 32'h1111_2222);

        // W ahead of AW, response stalled by bready
        bus.bready = 1'b0;
        b_q.push_back(OKAY);
        fork
            begin
                do_w(32'h3333_4444, 4'hF);
                chk("w_first_wready", bus.wready, 0);
                chk("w_first_awready", bus.awready, 1);
            end
            begin
                repeat (3) @(posedge aclk);
                #1;
                do_aw(12'h00C);
            end
        join
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            chk("bstall_bvalid", bus.bvalid, 1);
            chk("bstall_bresp", bus.bresp, OKAY);
        end
        bus.bready = 1'b1;
        wait_b_done();
        chk("cfg3_w_first", cfg[127:96], 32'h3333_4444);

        // fill FIFO with tready low, then overflow
        tready = 1'b0;
        for (int i = 1; i <= 16; i++) axi_write(12'h200, 32'(i), 4'hF, OKAY);
        axi_read(12'h204, 32'h0001_0010, OKAY);
        axi_write(12'h200, 32'd17, 4'hF, SLVERR);
        axi_read(12'h204, 32'h0003_0010, OKAY);
        for (int i = 1; i <= 16; i++) ax_q.push_back(32'(i));
        tready = 1'b1;
        wait_ax_done();
        chk("drain_tvalid", tvalid, 0);
        axi_read(12'h204, 32'h0002_0000, OKAY);
        axi_write(12'h208, 32'h1, 4'hF, OKAY);
        axi_read(12'h204, 32'h0, OKAY);

        // push with continuous tready
        ax_q.push_back(32'hCAFE_F00D);
        axi_write(12'h200, 32'hCAFE_F00D, 4'h0, OKAY);
        wait_ax_done();
        axi_read(12'h204, 32'h0, OKAY);

        // status, unmapped and read-only regions
        axi_read(12'h104, 32'hDEAD_BEEF, OKAY);
        axi_read(12'h100, 32'h1357_9BDF, OKAY);
        axi_read(12'h300, 32'h0, SLVERR);
        axi_read(12'h010, 32'h0, SLVERR);
        axi_read(12'h200, 32'h0, OKAY);
        axi_read(12'h208, 32'h0, OKAY);
        axi_write(12'h100, 32'hFFFF_FFFF, 4'hF, SLVERR);
        axi_write(12'h204, 32'hFFFF_FFFF, 4'hF, SLVERR);
        axi_write(12'h3F0, 32'hFFFF_FFFF, 4'hF, SLVERR);
        chk("ro_no_effect_cfg", cfg, {32'h3333_4444, 32'h1111_2222, 32'h0000_5A5A, 32'h0});
        axi_read(12'h100, 32'h1357_9BDF, OKAY);
        axi_read(12'h204, 32'h0, OKAY);

        // flush
        tready = 1'b0;
        for (int i = 0; i < 5; i++) axi_write(12'h200, 32'h100 + 32'(i), 4'hF, OKAY);
        axi_read(12'h204, 32'h0000_0005, OKAY);
        axi_write(12'h208, 32'h3, 4'hF, OKAY);
        axi_read(12'h204, 32'h0, OKAY);
        chk("flush_tvalid", tvalid, 0);
        tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;

        // reset while a write has only its address accepted
        do_aw(12'h000);
        areset = 1'b1;
        @(posedge aclk); #1;
        chk("midrst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk("midrst_bvalid", bus.bvalid, 0);
        chk("midrst_cfg", cfg, 128'h0);
        chk("midrst_tvalid", tvalid, 0);
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("postrst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        do_w(32'hDEAD_DEAD, 4'hF);
        repeat (5) @(posedge aclk);
        #1;
        chk("dropped_aw_bvalid", bus.bvalid, 0);
        chk("dropped_aw_cfg", cfg, 128'h0);
        b_q.push_back(OKAY);
        do_aw(12'h008);
        wait_b_done();
        chk("late_aw_cfg", cfg, {32'h0, 32'hDEAD_DEAD, 32'h0, 32'h0});

        repeat (5) @(posedge aclk);
        #1;
        chk("b_q_empty", 32'(b_q.size()), 0);
        chk("r_q_empty", 32'(r_q.size()), 0);
        chk("ax_q_empty", 32'(ax_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
